// File: rtl/hdmi_period_sequencer.sv
// Fixed-latency (11 clock) pipe that turns a VGA-style stream into per-channel TMDS period
// types, control bits and pixel bytes, inserting the video preamble and leading guard band.
module hdmi_period_sequencer #(
   parameter logic OPT_DVI = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic        i_de,
   input  logic [23:0] i_pixel,
   output logic        o_gtype,
   output logic [1:0]  o_dtype,
   output logic [5:0]  o_ctl,
   output logic [23:0] o_data,
   output logic        o_err
);

   localparam int LAST = 10;

   // Stage k of every delay line holds the sample taken k edges ago; stage LAST feeds the outputs.
   logic [LAST:0] de_q;
   logic [LAST:0] hs_q;
   logic [LAST:0] vs_q;
   logic [LAST:0] pre_q;
   logic [LAST:0] grd_q;
   logic [23:0]   pix_q [LAST+1];
   logic          err_pend;

   logic          rise;
   logic          short_gap;
   logic [LAST:0] pre_win;
   logic [LAST:0] grd_win;

   // A rise tags the ten samples already in flight ahead of it: two guard, then eight preamble.
   assign rise      = i_de & ~de_q[0] & ~OPT_DVI;
   assign short_gap = rise & (|de_q[LAST-1:0]);
   assign pre_win   = rise ? 11'h7F8 : 11'h000;
   assign grd_win   = rise ? 11'h006 : 11'h000;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         de_q     <= '0;
         hs_q     <= '0;
         vs_q     <= '0;
         pre_q    <= '0;
         grd_q    <= '0;
         for (int k = 0; k <= LAST; k++) begin
            pix_q[k] <= '0;
         end
         err_pend <= 1'b0;
         o_gtype  <= 1'b0;
         o_dtype  <= 2'b01;
         o_ctl    <= '0;
         o_data   <= '0;
         o_err    <= 1'b0;
      end else begin
         de_q     <= {de_q[LAST-1:0], i_de};
         hs_q     <= {hs_q[LAST-1:0], i_hsync};
         vs_q     <= {vs_q[LAST-1:0], i_vsync};
         pre_q    <= {pre_q[LAST-1:0], 1'b0} | pre_win;
         grd_q    <= {grd_q[LAST-1:0], 1'b0} | grd_win;
         pix_q[0] <= i_pixel;
         for (int k = 1; k <= LAST; k++) begin
            pix_q[k] <= pix_q[k-1];
         end
         err_pend <= short_gap;
         o_err    <= err_pend;
         o_gtype  <= 1'b0;

         // Slot priority: video, then guard, then preamble, then plain control.
         if (de_q[LAST]) begin
            o_dtype <= 2'b11;
            o_ctl   <= {4'b0000, vs_q[LAST], hs_q[LAST]};
            o_data  <= pix_q[LAST];
         end else if (grd_q[LAST]) begin
            o_dtype <= 2'b00;
            o_ctl   <= {4'b0000, vs_q[LAST], hs_q[LAST]};
            o_data  <= '0;
         end else if (pre_q[LAST]) begin
            o_dtype <= 2'b01;
            o_ctl   <= {4'b0001, vs_q[LAST], hs_q[LAST]};
            o_data  <= '0;
         end else begin
            o_dtype <= 2'b01;
            o_ctl   <= {4'b0000, vs_q[LAST], hs_q[LAST]};
            o_data  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Bench for hdmi_period_sequencer: directed line/sync/short-gap/reset cases plus random
// traffic, all checked every cycle against a slot-classification model of the stream.
module tb_hdmi_period_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hs = 1'b0;
   logic        vs = 1'b0;
   logic        de = 1'b0;
   logic [23:0] pix = '0;

   logic        a_gtype, b_gtype;
   logic [1:0]  a_dtype, b_dtype;
   logic [5:0]  a_ctl, b_ctl;
   logic [23:0] a_data, b_data;
   logic        a_err, b_err;

   int total = 0;
   int bad   = 0;
   int cnt   = 20;
   int base  = 20;

   // Input history indexed by edge number, and the observed outputs after each edge.
   logic        h_de  [4096];
   logic        h_hs  [4096];
   logic        h_vs  [4096];
   logic [23:0] h_pix [4096];
   logic [1:0]  t_dt  [4096];
   logic [5:0]  t_ctl [4096];
   logic [23:0] t_dat [4096];
   logic        t_err [4096];
   logic [1:0]  d_dt  [4096];
   logic [5:0]  d_ctl [4096];
   logic [23:0] d_dat [4096];
   logic        d_err [4096];

   always #5 clk = ~clk;

   hdmi_period_sequencer #(.OPT_DVI(1'b0)) u_dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_de(de), .i_pixel(pix),
      .o_gtype(a_gtype), .o_dtype(a_dtype), .o_ctl(a_ctl), .o_data(a_data), .o_err(a_err)
   );

   hdmi_period_sequencer #(.OPT_DVI(1'b1)) u_dvi (
      .i_clk(clk), .i_reset_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_de(de), .i_pixel(pix),
      .o_gtype(b_gtype), .o_dtype(b_dtype), .o_ctl(b_ctl), .o_data(b_data), .o_err(b_err)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit rise_at(int r);
      if (r < base) return 1'b0;
      return h_de[r] && !h_de[r-1];
   endfunction

   // Expected outputs after edge e, from the slot rules applied to sample e-11.
   function automatic void model(input int e, input bit dvi, output logic [1:0] dt,
                                 output logic [5:0] ctl, output logic [23:0] dat, output logic err);
      int m;
      bit grd;
      bit pre;
      bit seen;
      m    = e - 11;
      grd  = 1'b0;
      pre  = 1'b0;
      seen = 1'b0;
      for (int r = m + 1; r <= m + 2; r++) if (rise_at(r)) grd = 1'b1;
      for (int r = m + 3; r <= m + 10; r++) if (rise_at(r)) pre = 1'b1;
      if (dvi) begin
         grd = 1'b0;
         pre = 1'b0;
      end
      ctl = {4'b0000, h_vs[m], h_hs[m]};
      dat = '0;
      if (h_de[m]) begin
         dt  = 2'b11;
         dat = h_pix[m];
      end else if (grd) begin
         dt = 2'b00;
      end else begin
         dt = 2'b01;
         if (pre) ctl[3:2] = 2'b01;
      end
      for (int i = e - 11; i <= e - 2; i++) seen |= h_de[i];
      err = !dvi && rise_at(e - 1) && seen;
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         h_de[cnt]  = de;
         h_hs[cnt]  = hs;
         h_vs[cnt]  = vs;
         h_pix[cnt] = pix;
         cnt++;
      end
   end

   int          ce;
   logic [1:0]  edt;
   logic [5:0]  ectl;
   logic [23:0] edat;
   logic        eerr;

   // Every cycle: reset values while held, otherwise both instances against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("rst_dtype", 32'(a_dtype), 32'd1);
         checkOutput("rst_ctl", 32'(a_ctl), 32'd0);
         checkOutput("rst_data", 32'(a_data), 32'd0);
         checkOutput("rst_err", 32'(a_err), 32'd0);
      end else if (cnt > base) begin
         ce = cnt - 1;
         t_dt[ce] = a_dtype; t_ctl[ce] = a_ctl; t_dat[ce] = a_data; t_err[ce] = a_err;
         d_dt[ce] = b_dtype; d_ctl[ce] = b_ctl; d_dat[ce] = b_data; d_err[ce] = b_err;
         model(ce, 1'b0, edt, ectl, edat, eerr);
         checkOutput("dtype", 32'(a_dtype), 32'(edt));
         checkOutput("ctl", 32'(a_ctl), 32'(ectl));
         checkOutput("data", 32'(a_data), 32'(edat));
         checkOutput("err", 32'(a_err), 32'(eerr));
         checkOutput("gtype", 32'(a_gtype), 32'd0);
         model(ce, 1'b1, edt, ectl, edat, eerr);
         checkOutput("dvi_dtype", 32'(b_dtype), 32'(edt));
         checkOutput("dvi_ctl", 32'(b_ctl), 32'(ectl));
         checkOutput("dvi_data", 32'(b_data), 32'(edat));
         checkOutput("dvi_err", 32'(b_err), 32'(eerr));
         checkOutput("dvi_gtype", 32'(b_gtype), 32'd0);
      end
   end

   task automatic applyStimulus(input logic d, input logic h, input logic v, input logic [23:0] p);
      @(negedge clk);
      de  = d;
      hs  = h;
      vs  = v;
      pix = p;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
   endtask

   task automatic doReset(input int cycles);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      de = 1'b0; hs = 1'b0; vs = 1'b0; pix = '0;
      for (int i = cnt - 11; i < cnt; i++) begin
         h_de[i] = 1'b0; h_hs[i] = 1'b0; h_vs[i] = 1'b0; h_pix[i] = '0;
      end
      base = cnt;
      #1;
      checkOutput("async_rst_dtype", 32'(a_dtype), 32'd1);
      checkOutput("async_rst_ctl", 32'(a_ctl), 32'd0);
      checkOutput("async_rst_data", 32'(a_data), 32'd0);
      checkOutput("async_rst_err", 32'(a_err), 32'd0);
      repeat (cycles) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Literal 8 preamble + 2 guard + first pixel around a rise sampled on edge n (syncs 0).
   task automatic checkLine(input int n, input logic [23:0] p0);
      for (int k = 1; k <= 8; k++) begin
         checkOutput("lit_pre_dtype", 32'(t_dt[n+k]), 32'd1);
         checkOutput("lit_pre_ctl", 32'(t_ctl[n+k]), 32'h04);
         checkOutput("lit_dvi_ctl", 32'(d_ctl[n+k]), 32'h00);
      end
      for (int k = 9; k <= 10; k++) begin
         checkOutput("lit_guard_dtype", 32'(t_dt[n+k]), 32'd0);
         checkOutput("lit_guard_ctl", 32'(t_ctl[n+k]), 32'h00);
         checkOutput("lit_dvi_ctl_dtype", 32'(d_dt[n+k]), 32'd1);
      end
      checkOutput("lit_first_dtype", 32'(t_dt[n+11]), 32'd3);
      checkOutput("lit_first_data", 32'(t_dat[n+11]), 32'(p0));
      checkOutput("lit_dvi_first_data", 32'(d_dat[n+11]), 32'(p0));
   endtask

   int n0, n1, nb, errs;
   logic [23:0] line_pix [4];

   initial begin
      for (int i = 0; i < 4096; i++) begin
         h_de[i] = 1'b0; h_hs[i] = 1'b0; h_vs[i] = 1'b0; h_pix[i] = '0;
      end
      line_pix[0] = 24'h112233; line_pix[1] = 24'h445566;
      line_pix[2] = 24'h778899; line_pix[3] = 24'hAABBCC;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Single line.
      idle(20);
      applyStimulus(1'b1, 1'b0, 1'b0, line_pix[0]);
      n0 = cnt;
      for (int i = 1; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, line_pix[i]);
      idle(18);
      checkLine(n0, 24'h112233);
      for (int i = 1; i < 4; i++) begin
         checkOutput("lit_line_data", 32'(t_dat[n0+11+i]), 32'(line_pix[i]));
         checkOutput("lit_dvi_line_data", 32'(d_dat[n0+11+i]), 32'(line_pix[i]));
      end
      checkOutput("lit_after_dtype", 32'(t_dt[n0+15]), 32'd1);
      errs = 0;
      for (int e = n0; e <= n0 + 15; e++) errs += int'(t_err[e]) + int'(d_err[e]);
      checkOutput("lit_line_err_count", 32'(errs), 32'd0);

      // Sync latency.
      applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
      n0 = cnt;
      applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 24'h0);
      idle(14);
      checkOutput("lit_sync0", 32'(t_ctl[n0+11]), 32'h1);
      checkOutput("lit_sync1", 32'(t_ctl[n0+12]), 32'h2);
      checkOutput("lit_sync2", 32'(t_ctl[n0+13]), 32'h3);
      checkOutput("lit_sync3", 32'(t_ctl[n0+14]), 32'h0);

      // Short gap: 4 high, 5 low, 4 high.
      applyStimulus(1'b1, 1'b0, 1'b0, 24'h000001);
      n1 = cnt;
      for (int i = 1; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'(i + 1));
      idle(5);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'(32'h100 + i));
      idle(16);
      checkLine(n1, 24'h000001);
      for (int i = 0; i < 4; i++) begin
         checkOutput("lit_gap_pix_a", 32'(t_dat[n1+11+i]), 32'(i + 1));
         checkOutput("lit_gap_pix_b", 32'(t_dat[n1+20+i]), 32'(32'h100 + i));
         checkOutput("lit_gap_vid_b", 32'(t_dt[n1+20+i]), 32'd3);
      end
      for (int k = 15; k <= 17; k++) begin
         checkOutput("lit_gap_pre_dtype", 32'(t_dt[n1+k]), 32'd1);
         checkOutput("lit_gap_pre_ctl", 32'(t_ctl[n1+k]), 32'h04);
      end
      for (int k = 18; k <= 19; k++) checkOutput("lit_gap_guard", 32'(t_dt[n1+k]), 32'd0);
      checkOutput("lit_gap_err_edge", 32'(t_err[n1+10]), 32'd1);
      errs = 0;
      for (int e = n1; e <= n1 + 23; e++) errs += int'(t_err[e]);
      checkOutput("lit_gap_err_count", 32'(errs), 32'd1);
      errs = 0;
      for (int e = n1; e <= n1 + 23; e++) errs += int'(d_err[e]);
      checkOutput("lit_dvi_err_count", 32'(errs), 32'd0);

      // Reset three cycles into a preamble, then a fresh line.
      idle(15);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'(32'hC0 + i));
      doReset(3);
      nb = base;
      idle(15);
      applyStimulus(1'b1, 1'b0, 1'b0, 24'h5A5A5A);
      n0 = cnt;
      applyStimulus(1'b1, 1'b0, 1'b0, 24'h123456);
      applyStimulus(1'b1, 1'b0, 1'b0, 24'h654321);
      idle(16);
      for (int e = nb; e <= nb + 10; e++) begin
         checkOutput("lit_post_rst_dtype", 32'(t_dt[e]), 32'd1);
         checkOutput("lit_post_rst_ctl", 32'(t_ctl[e]), 32'h0);
      end
      checkLine(n0, 24'h5A5A5A);

      // Random traffic with occasional resets.
      while (cnt < 3800) begin
         int runl;
         int gapl;
         runl = $urandom_range(1, 24);
         gapl = $urandom_range(1, 16);
         for (int i = 0; i < runl; i++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
         for (int i = 0; i < gapl; i++)
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
         if ($urandom_range(0, 25) == 0) doReset($urandom_range(1, 3));
      end
      idle(15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
